instr_fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the MIPS core. It replaces direct indexing of the flat instruction-stream vector with a PC register, a prefetch queue and a valid/ready handshake toward decode. It accepts branch/jump/jr redirects from execute and flushes stale prefetches. It also reports end-of-program and faulting redirect targets.

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit_queue.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        END   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam int INSTR_W  = 32;
    localparam int BYTE_OFF = 2;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake plus the redirect request coming back from execute.
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 12
) ();

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus4;

    modport master (
        input  redirect_valid, redirect_addr, out_ready,
        output out_valid, out_instr, out_pc, out_pc_plus4
    );

    modport slave (
        output redirect_valid, redirect_addr, out_ready,
        input  out_valid, out_instr, out_pc, out_pc_plus4
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Small synchronous FIFO holding prefetched {instr, pc} entries; flush beats push/pop.
module fetch_queue #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full queue needs for the push.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) storage[wr_ptr_q] <= push_data;
    end

    assign head_data = storage[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC register, prefetch queue, redirect/flush and end/fault tracking.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int ADDR_W     = 12,
    parameter int FQ_DEPTH   = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IMEM_WORDS*INSTR_W-1:0]   instr_mem,
    instr_fetch_unit_if.master              bus,
    output logic [$clog2(FQ_DEPTH+1)-1:0]   occupancy,
    output logic                            halted,
    output logic                            fault
);

    if (IMEM_WORDS*4 > 2**ADDR_W) begin : g_bad_size
        $error("IMEM_WORDS*4 exceeds the PC address space");
    end
    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH-1)) != 0) begin : g_bad_depth
        $error("FQ_DEPTH must be a power of two and at least 2");
    end
    if (RESET_PC % 4 != 0 || RESET_PC >= IMEM_WORDS*4) begin : g_bad_reset_pc
        $error("RESET_PC must be word-aligned and inside memory");
    end

    localparam int               WIDX_W     = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [ADDR_W:0]  IMEM_BYTES = (ADDR_W+1)'(IMEM_WORDS*4);

    fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W:0]   pc_plus4_wide;
    logic [WIDX_W-1:0] word_idx;
    logic [IMEM_WORDS-1:0][INSTR_W-1:0] mem_words;

    logic                      q_push, q_pop, q_flush, q_full, q_empty;
    logic [INSTR_W+ADDR_W-1:0] q_head;
    logic [ADDR_W-1:0]         head_pc;
    logic                      pop_req, redir_bad;

    assign mem_words     = instr_mem;
    assign word_idx      = pc_q[BYTE_OFF +: WIDX_W];
    assign pc_plus4      = pc_q + ADDR_W'(4);
    // One extra bit so the end-of-memory compare still works when memory fills the PC space.
    assign pc_plus4_wide = {1'b0, pc_q} + (ADDR_W+1)'(4);
    assign pop_req       = bus.out_valid && bus.out_ready;
    assign redir_bad     = (bus.redirect_addr[BYTE_OFF-1:0] != '0) ||
                           ({1'b0, bus.redirect_addr} >= IMEM_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        q_push  = 1'b0;
        q_pop   = pop_req;
        q_flush = 1'b0;
        if (bus.redirect_valid && state_q != FAULT) begin
            q_flush = 1'b1;
            q_pop   = 1'b0;
            if (redir_bad) begin
                state_d = FAULT;
            end else begin
                state_d = FETCH;
                pc_d    = bus.redirect_addr;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!q_full || pop_req) begin
                        q_push = 1'b1;
                        pc_d   = pc_plus4;
                        if (pc_plus4_wide == IMEM_BYTES) state_d = END;
                    end
                end
                END:     if (q_empty) state_d = HALT;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({mem_words[word_idx], pc_q}),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occupancy)
    );

    assign head_pc          = q_head[ADDR_W-1:0];
    assign bus.out_valid    = !q_empty;
    assign bus.out_instr    = q_empty ? NOP : q_head[ADDR_W +: INSTR_W];
    assign bus.out_pc       = q_empty ? '0 : head_pc;
    assign bus.out_pc_plus4 = q_empty ? '0 : head_pc + ADDR_W'(4);
    assign halted           = (state_q == HALT);
    assign fault            = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table plus scoreboard on a 1024-word core, end-of-memory on an 8-word core.
module tb_instr_fetch_unit;

    localparam int BIG_BYTES   = 4096;
    localparam int SMALL_WORDS = 8;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [11:0] raddr;
        logic        exp_v;
        int unsigned exp_pc;
        int unsigned exp_occ;
        logic        exp_fault;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic [1024*32-1:0]        imem;
    logic [SMALL_WORDS*32-1:0] smem;
    logic [2:0]                big_occ, small_occ;
    logic                      big_halted, big_fault, small_halted, small_fault;

    instr_fetch_unit_if #(.ADDR_W(12)) big_if ();
    instr_fetch_unit_if #(.ADDR_W(12)) small_if ();

    instr_fetch_unit #(
        .IMEM_WORDS(1024), .ADDR_W(12), .FQ_DEPTH(4), .RESET_PC(0)
    ) u_dut (
        .clk(clk), .rst(rst_n), .instr_mem(imem), .bus(big_if),
        .occupancy(big_occ), .halted(big_halted), .fault(big_fault)
    );

    instr_fetch_unit #(
        .IMEM_WORDS(SMALL_WORDS), .ADDR_W(12), .FQ_DEPTH(4), .RESET_PC(0)
    ) u_small (
        .clk(clk), .rst(rst_n), .instr_mem(smem), .bus(small_if),
        .occupancy(small_occ), .halted(small_halted), .fault(small_fault)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned sb[$];
    int unsigned small_exp[$];
    bit          model_fault;
    vec_t        tbl [23];

    function automatic logic [31:0] model_word(input int unsigned k);
        case (k)
            0:       return 32'h2001_0005;   // addi $1,$0,5
            1:       return 32'h2002_0002;   // addi $2,$0,2
            2:       return 32'h2003_0007;   // addi $3,$0,7
            default: return 32'hA000_0000 | k;
        endcase
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [11:0] ra,
                                input logic v, input int unsigned pc, input int unsigned occ,
                                input logic flt);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.raddr = ra;
        r.exp_v = v; r.exp_pc = pc; r.exp_occ = occ; r.exp_fault = flt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_big(input string tag, input logic v, input int unsigned pc,
                             input int unsigned occ, input logic flt, input logic hlt);
        check({tag, ".valid"},  32'(big_if.out_valid),    32'(v));
        check({tag, ".pc"},     32'(big_if.out_pc),       v ? pc : 32'd0);
        check({tag, ".instr"},  big_if.out_instr,         v ? model_word(pc / 4) : 32'd0);
        check({tag, ".plus4"},  32'(big_if.out_pc_plus4), v ? pc + 4 : 32'd0);
        check({tag, ".occ"},    32'(big_occ),             occ);
        check({tag, ".fault"},  32'(big_fault),           32'(flt));
        check({tag, ".halted"}, 32'(big_halted),          32'(hlt));
    endtask

    task automatic sb_fill(input int unsigned start);
        for (int i = 0; i < 40; i++)
            if (start + 4 * i < BIG_BYTES) sb.push_back(start + 4 * i);
    endtask

    task automatic model_reset();
        model_fault = 1'b0;
        sb.delete();
        sb_fill(0);
    endtask

    // Called mid-cycle: the handshake seen here is the one the next rising edge acts on.
    task automatic monitor_big();
        int unsigned exp;
        if (big_if.redirect_valid) begin
            if (!model_fault) begin
                sb.delete();
                if (big_if.redirect_addr[1:0] != 2'b00 || int'(big_if.redirect_addr) >= BIG_BYTES)
                    model_fault = 1'b1;
                else
                    sb_fill(big_if.redirect_addr);
            end
        end else if (big_if.out_valid && big_if.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb.underflow: got pc %0d, expected no delivery", big_if.out_pc);
            end else begin
                exp = sb.pop_front();
                $display("txn big pc=%0d instr=%08h plus4=%0d", big_if.out_pc, big_if.out_instr,
                         big_if.out_pc_plus4);
                check("sb.pc",    32'(big_if.out_pc),       exp);
                check("sb.instr", big_if.out_instr,         model_word(exp / 4));
                check("sb.plus4", 32'(big_if.out_pc_plus4), exp + 4);
            end
        end
    endtask

    task automatic step_big(input logic rdy, input logic rv, input logic [11:0] addr);
        big_if.out_ready      = rdy;
        big_if.redirect_valid = rv;
        big_if.redirect_addr  = addr;
        @(negedge clk);
        monitor_big();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp;
        for (int k = 0; k < 1024; k++) imem[32*k +: 32] = model_word(k);
        for (int k = 0; k < SMALL_WORDS; k++) smem[32*k +: 32] = model_word(k);
        big_if.out_ready        = 1'b0;
        big_if.redirect_valid   = 1'b0;
        big_if.redirect_addr    = '0;
        small_if.out_ready      = 1'b0;
        small_if.redirect_valid = 1'b0;
        small_if.redirect_addr  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_big("reset", 1'b0, 0, 0, 1'b0, 1'b0);
        check("reset.small_valid", 32'(small_if.out_valid), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Backpressure, release, redirect while full, then a faulting redirect.
        for (int i = 0; i < 10; i++) tbl[i] = mk(0, 0, 0, 1, 0, (i < 3) ? i + 1 : 4, 0);
        tbl[10] = mk(1, 0, 0,  1, 4,  4, 0);
        tbl[11] = mk(1, 0, 0,  1, 8,  4, 0);
        tbl[12] = mk(1, 0, 0,  1, 12, 4, 0);
        tbl[13] = mk(1, 0, 0,  1, 16, 4, 0);
        tbl[14] = mk(1, 0, 0,  1, 20, 4, 0);
        tbl[15] = mk(1, 1, 52, 0, 0,  0, 0);
        tbl[16] = mk(1, 0, 0,  1, 52, 1, 0);
        tbl[17] = mk(1, 0, 0,  1, 56, 1, 0);
        tbl[18] = mk(0, 0, 0,  1, 56, 2, 0);
        tbl[19] = mk(0, 0, 0,  1, 56, 3, 0);
        tbl[20] = mk(0, 1, 6,  0, 0,  0, 1);
        tbl[21] = mk(1, 1, 0,  0, 0,  0, 1);
        tbl[22] = mk(1, 0, 0,  0, 0,  0, 1);
        for (int i = 0; i < 23; i++) begin
            step_big(tbl[i].rdy, tbl[i].rv, tbl[i].raddr);
            check_big($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_pc, tbl[i].exp_occ,
                      tbl[i].exp_fault, 1'b0);
        end

        // Mid-cycle reset clears the sticky fault without waiting for a clock.
        #3 rst_n = 1'b0;
        #1 check_big("fault_clear", 1'b0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step_big(1, 0, 0);
            check_big($sformatf("seq%0d", i), 1'b1, 4 * i, 1, 1'b0, 1'b0);
        end

        // Build up three entries, then reset between edges.
        step_big(0, 0, 0);
        step_big(0, 0, 0);
        check_big("occ3", 1'b1, 20, 3, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1 check_big("midrst", 1'b0, 0, 0, 1'b0, 1'b0);
        check("midrst.small_occ", 32'(small_occ), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        step_big(1, 0, 0);
        check_big("restart", 1'b1, 0, 1, 1'b0, 1'b0);

        // 8-word core: run off the end, drain, halt, then resume and fault on the boundary.
        for (int i = 0; i < SMALL_WORDS; i++) small_exp.push_back(4 * i);
        small_if.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (small_if.out_valid && small_if.out_ready) begin
                if (small_exp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL small.extra: got pc %0d, expected no delivery", small_if.out_pc);
                end else begin
                    exp = small_exp.pop_front();
                    $display("txn small pc=%0d instr=%08h", small_if.out_pc, small_if.out_instr);
                    check("small.pc",    32'(small_if.out_pc), exp);
                    check("small.instr", small_if.out_instr,   model_word(exp / 4));
                end
            end
            @(posedge clk);
            #1;
        end
        check("small.remaining", 32'(small_exp.size()), 32'd0);
        check("small.halted",    32'(small_halted),     32'd1);
        check("small.valid_end", 32'(small_if.out_valid), 32'd0);
        check("small.occ_end",   32'(small_occ),        32'd0);

        small_if.redirect_valid = 1'b1;
        small_if.redirect_addr  = 12'd8;
        @(posedge clk);
        #1;
        check("resume.valid0", 32'(small_if.out_valid), 32'd0);
        check("resume.halted", 32'(small_halted),       32'd0);
        small_if.redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        check("resume.valid1", 32'(small_if.out_valid), 32'd1);
        check("resume.pc",     32'(small_if.out_pc),    32'd8);
        check("resume.instr",  small_if.out_instr,      model_word(2));
        check("resume.plus4",  32'(small_if.out_pc_plus4), 32'd12);

        small_if.redirect_valid = 1'b1;
        small_if.redirect_addr  = 12'd32;
        @(posedge clk);
        #1;
        small_if.redirect_valid = 1'b0;
        check("range.fault", 32'(small_fault),        32'd1);
        check("range.valid", 32'(small_if.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
